// File: rtl/am2940_pkg.sv
// Shared Am2940 definitions: transfer mode encodings, word counter FSM states,
// default slice width and the mode direction helper.
package am2940_pkg;

  localparam int WC_WIDTH = 4;

  localparam logic [1:0] MODE_WC_DOWN  = 2'b00;
  localparam logic [1:0] MODE_WC_UP    = 2'b01;
  localparam logic [1:0] MODE_ADDR_CMP = 2'b10;
  localparam logic [1:0] MODE_FREE     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_HALTED = 2'b10
  } wc_state_t;

  // Up-counting modes start from zero; the others count down from the word register
  function automatic logic mode_is_up(input logic [1:0] mode);
    logic up;
    case (mode)
      MODE_WC_UP, MODE_ADDR_CMP: up = 1'b1;
      MODE_WC_DOWN, MODE_FREE:   up = 1'b0;
      default:                   up = 1'b0;
    endcase
    return up;
  endfunction

endpackage

// File: rtl/wc_updown.sv
// Combinational WIDTH-bit up/down stepper with carry-in and carry/borrow-out,
// shared by the word counter and the address counter.
module wc_updown #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic             up,
  input  logic             ci,
  output logic [WIDTH-1:0] count_next,
  output logic             co
);

  logic [WIDTH-1:0] incr_s;

  assign incr_s     = {{(WIDTH-1){1'b0}}, ci};
  assign count_next = up ? (value + incr_s) : (value - incr_s);
  assign co         = ci & (up ? (&value) : ~(|value));

endmodule

// File: rtl/am2940_word_counter.sv
// Am2940 word register / word counter slice with IDLE/ACTIVE/HALTED control.
// Define WC_AUTO_REINIT_EN to reload on done instead of halting.
module am2940_word_counter
  import am2940_pkg::*;
#(
  parameter int WIDTH = WC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_word,
  input  logic             reinit,
  input  logic [1:0]       mode,
  input  logic             wci,
  input  logic             done_in,
  output logic [WIDTH-1:0] word_count_val,
  output logic [WIDTH-1:0] word_reg_val,
  output logic             wco,
  output logic             busy
);

  wc_state_t        state_r;
  logic [WIDTH-1:0] word_count_r;
  logic [WIDTH-1:0] word_reg_r;
  logic             busy_r;
  logic [WIDTH-1:0] start_val_s;
  logic [WIDTH-1:0] count_next_s;
  logic             up_s;
  logic             active_s;
  logic             halt_s;
  logic             step_s;
  logic             co_s;

  assign up_s     = mode_is_up(mode);
  assign active_s = (state_r == ST_ACTIVE);
  // Free-run mode ignores done so a cascaded slice can keep wrapping
  assign halt_s   = active_s & done_in & (mode != MODE_FREE);
  assign step_s   = wci & active_s & ~load_word & ~reinit & ~halt_s;

  // Start value the counter returns to on reinit or auto-reload
  always_comb begin
    start_val_s = {WIDTH{1'b0}};
    case (mode)
      MODE_WC_DOWN, MODE_FREE:   start_val_s = word_reg_r;
      MODE_WC_UP, MODE_ADDR_CMP: start_val_s = {WIDTH{1'b0}};
      default:                   start_val_s = {WIDTH{1'b0}};
    endcase
  end

  wc_updown #(.WIDTH(WIDTH)) u_step (
    .value      (word_count_r),
    .up         (up_s),
    .ci         (step_s),
    .count_next (count_next_s),
    .co         (co_s)
  );

  // Control FSM with counter/register updates in priority order
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      word_count_r <= {WIDTH{1'b0}};
      word_reg_r   <= {WIDTH{1'b0}};
      busy_r       <= 1'b0;
    end else if (load_word) begin
      word_reg_r   <= data_in;
      word_count_r <= up_s ? {WIDTH{1'b0}} : data_in;
      state_r      <= ST_ACTIVE;
      busy_r       <= 1'b1;
    end else if (reinit && (state_r != ST_IDLE)) begin
      word_count_r <= start_val_s;
      state_r      <= ST_ACTIVE;
      busy_r       <= 1'b1;
    end else if (halt_s) begin
`ifdef WC_AUTO_REINIT_EN
      word_count_r <= start_val_s;
      state_r      <= ST_ACTIVE;
      busy_r       <= 1'b1;
`else
      state_r      <= ST_HALTED;
      busy_r       <= 1'b0;
`endif
    end else if (step_s) begin
      word_count_r <= count_next_s;
    end else begin
      word_count_r <= word_count_r;
    end
  end

  assign word_count_val = word_count_r;
  assign word_reg_val   = word_reg_r;
  assign busy           = busy_r;
  assign wco            = co_s;

endmodule

// File: doc/am2940_word_counter.md
# am2940_word_counter

Word register and word counter stage of the Am2940 DMA address generator; it sits directly upstream of `done_gen`. It holds the programmed transfer length, steps the word counter once per word under the WCI carry-in, and drives `word_count_val`, `word_reg_val` and the carry-out `wco` that `done_gen` and downstream cascaded slices consume. A small control FSM blocks counting until the counter is loaded and halts it on the terminal count reported back by `done_gen`.

## Interface
- `WIDTH`, 4, counter and register width (one Am2940 slice)
- `clk` in 1: sole clock, rising edge
- `rst` in 1: one clock; reset is synchronous and active-high
- `data_in` in WIDTH: value to load into word register and counter
- `load_word` in 1: load `data_in` into word register and counter
- `reinit` in 1: reload counter with its mode start value
- `mode` in 2: transfer mode, shared with `done_gen`
- `wci` in 1: word count carry-in, step enable (active-high)
- `done_in` in 1: `done` from `done_gen`
- `word_count_val` out WIDTH: registered counter value
- `word_reg_val` out WIDTH: registered word register
- `wco` out 1: combinational carry/borrow out for cascading
- `busy` out 1: high in ACTIVE

## Operation
- Mode start values: 00 (count down to zero) = `word_reg`; 01 (count up to word reg) = 0; 10 (address compare) = 0; 11 (free run) = `word_reg`.
- Direction: modes 00, 11 decrement; 01, 10 increment; modulo 2^WIDTH, wrap silently.
- `load_word`: `word_reg` <= `data_in`; counter <= `data_in` in modes 00/11, 0 in modes 01/10; state -> ACTIVE.
- `reinit`: counter <= start value of current mode; `word_reg` unchanged; IDLE stays IDLE, HALTED -> ACTIVE, ACTIVE stays ACTIVE.
- step = `wci` && state==ACTIVE && no `load_word`/`reinit` this cycle.
- `wco` = step && (down: count==0; up: count==all-ones). Forced 0 in IDLE and HALTED.
- FSM states IDLE, ACTIVE, HALTED:
  - IDLE -> ACTIVE on `load_word`; `reinit` ignored in IDLE (no program yet).
  - ACTIVE -> HALTED when `done_in` high and mode != 11 (step suppressed that cycle); mode 11 never halts.
  - HALTED -> ACTIVE on `load_word` or `reinit`.
- Priority: `rst` > `load_word` > `reinit` > done/halt > step.
- Mode change while ACTIVE: direction changes from next step; counter not reloaded.

## Timing
- Reset values: `word_count_val` 0, `word_reg_val` 0, state IDLE, `busy` 0, `wco` 0.
- Load/reinit/step take effect on the edge after the request; `word_count_val` is valid one cycle later.
- `wco` zero-latency from `wci` (same cycle as the step it accompanies).
- `done_in` is sampled at the edge; HALTED and `busy`=0 are visible the following cycle; no step occurs on that edge.
- `rst` mid-transfer: all state to reset values on that edge, regardless of other inputs.
- `load_word` and `done_in` in the same cycle: load wins, state ACTIVE.

## Configuration
- `WC_AUTO_REINIT_EN` defined: ACTIVE with `done_in` (mode != 11) reloads counter with the mode start value and stays ACTIVE (`busy` stays 1); HALTED is unreachable.
- Not defined: behaviour as above (halt on done until `load_word`/`reinit`).

## Structure
- Shared package `am2940_pkg`: mode constants MODE_WC_DOWN=2'b00, MODE_WC_UP=2'b01, MODE_ADDR_CMP=2'b10, MODE_FREE=2'b11; FSM state typedef; default WIDTH constant. `done_gen` is moved onto the same mode constants.
- One sub-module, `wc_updown`: combinational WIDTH-bit up/down step with carry-in/carry-out, reused later by the address counter.

## Test plan
- Reset then `wci`=1 for 3 cycles -> count stays 0, `busy` 0, `wco` 0.
- Mode 00, load 4'h3, `wci`=1 -> count 3,2,1,0; `wco`=1 on step from 0; `done_in`=1 at 0 -> HALTED, count holds 0 (with macro: reload 3, `busy` stays 1).
- Mode 01, load 4'hA -> count 0, steps to 4'hA; `word_reg_val`=4'hA throughout; `reinit` from HALTED -> count 0, ACTIVE.
- Mode 11, load 4'h1, `wci`=1, `done_in`=1 -> 1,0,F,E; `wco` high on step from 0; never halts.
- `wci` toggling 1,0,1 in mode 10 from 4'hE -> E,F,F,0 with `wco` high only on F->0.
- `load_word`=4'h5 with `done_in`=1 same cycle -> ACTIVE, count 5; `rst` mid-count -> all outputs 0 next cycle.
